// File: rtl/hugo_round_sequencer.sv
// Round controller for the reaction game: idle, random wait, GO cue, then a scored result or a fault.
// Optional best-score register is enabled with `define HUGO_BEST_SCORE_EN.
module hugo_round_sequencer #(
  parameter int unsigned TICK_DIV = 10000,
  parameter int unsigned MIN_WAIT = 500,
  parameter int unsigned TIMEOUT  = 999
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       btn_start,
  input  logic       btn_react,
  output logic [2:0] state,
  output logic       go_led,
  output logic [9:0] score,
  output logic       result_valid,
  output logic       fault,
  output logic       timeout,
  output logic [9:0] best_time
);

  // state | meaning
  // IDLE  | waiting for the first start press
  // WAIT  | random delay running, an early react press is a fault
  // GO    | cue lit, reaction-time counter running
  // RESULT| score holds a completed (or timed-out) round
  // FAULT | react was pressed before the cue
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_GO     = 3'd2,
    S_RESULT = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  localparam int unsigned    PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [10:0]    MIN_WAIT_W = 11'(MIN_WAIT);
  localparam logic [9:0]     RT_LAST    = 10'(TIMEOUT - 1);
  localparam logic [9:0]     TIMEOUT_W  = 10'(TIMEOUT);

  state_t        state_q;
  logic [PW-1:0] presc_q;
  logic [15:0]   lfsr_q;
  logic [15:0]   lfsr_d;
  logic [10:0]   delay_q;
  logic [10:0]   delay_d;
  logic [9:0]    rt_q;
  logic [9:0]    score_q;
  logic          start_prev_q;
  logic          react_prev_q;
  logic          go_led_q;
  logic          result_valid_q;
  logic          fault_q;
  logic          timeout_q;
  logic          start_edge;
  logic          react_edge;
  logic          tick;

  always_comb begin
    start_edge = btn_start & ~start_prev_q;
    react_edge = btn_react & ~react_prev_q;
    tick       = (presc_q == PRESC_LAST);
    lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    delay_d    = MIN_WAIT_W + {1'b0, lfsr_q[9:0]};
  end

  // Button history keeps tracking while frozen, so presses during ena=0 are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_prev_q <= 1'b1;
      react_prev_q <= 1'b1;
    end else begin
      start_prev_q <= btn_start;
      react_prev_q <= btn_react;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      presc_q        <= '0;
      lfsr_q         <= 16'hACE1;
      delay_q        <= '0;
      rt_q           <= '0;
      score_q        <= '0;
      go_led_q       <= 1'b0;
      result_valid_q <= 1'b0;
      fault_q        <= 1'b0;
      timeout_q      <= 1'b0;
    end else if (ena) begin
      lfsr_q  <= lfsr_d;
      presc_q <= tick ? '0 : presc_q + 1'b1;
      case (state_q)
        S_IDLE: begin
          if (start_edge) begin
            state_q <= S_WAIT;
            delay_q <= delay_d;
            presc_q <= '0;
          end
        end
        S_WAIT: begin
          if (react_edge) begin
            state_q <= S_FAULT;
            fault_q <= 1'b1;
            presc_q <= '0;
          end else if (tick) begin
            if (delay_q == '0) begin
              state_q  <= S_GO;
              go_led_q <= 1'b1;
              rt_q     <= '0;
              presc_q  <= '0;
            end else begin
              delay_q <= delay_q - 1'b1;
            end
          end
        end
        S_GO: begin
          // A react press beats a timeout tick landing on the same edge.
          if (react_edge) begin
            state_q        <= S_RESULT;
            go_led_q       <= 1'b0;
            result_valid_q <= 1'b1;
            score_q        <= rt_q;
            timeout_q      <= 1'b0;
            presc_q        <= '0;
          end else if (tick) begin
            if (rt_q == RT_LAST) begin
              state_q        <= S_RESULT;
              go_led_q       <= 1'b0;
              result_valid_q <= 1'b1;
              score_q        <= TIMEOUT_W;
              timeout_q      <= 1'b1;
              presc_q        <= '0;
            end else begin
              rt_q <= rt_q + 1'b1;
            end
          end
        end
        S_RESULT, S_FAULT: begin
          if (start_edge) begin
            state_q        <= S_WAIT;
            delay_q        <= delay_d;
            result_valid_q <= 1'b0;
            fault_q        <= 1'b0;
            timeout_q      <= 1'b0;
            presc_q        <= '0;
          end
        end
        default: begin
          state_q        <= S_IDLE;
          go_led_q       <= 1'b0;
          result_valid_q <= 1'b0;
          fault_q        <= 1'b0;
          presc_q        <= '0;
        end
      endcase
    end
  end

`ifdef HUGO_BEST_SCORE_EN
  logic [9:0] best_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      best_q <= 10'h3FF;
    end else if (ena && (state_q == S_GO) && react_edge && (rt_q < best_q)) begin
      best_q <= rt_q;
    end
  end

  assign best_time = best_q;
`else
  assign best_time = 10'h3FF;
`endif

  assign state        = state_q;
  assign go_led       = go_led_q;
  assign score        = score_q;
  assign result_valid = result_valid_q;
  assign fault        = fault_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_hugo_round_sequencer.sv
// Bench for hugo_round_sequencer: vector table, directed GO-phase rounds and a random run
// checked against a round-level reference model.
module tb_hugo_round_sequencer;

  localparam int TD = 4;
  localparam int MW = 2;
  localparam int TO = 8;
`ifdef HUGO_BEST_SCORE_EN
  localparam bit BEST_EN = 1'b1;
`else
  localparam bit BEST_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, ena, bs, br;
  logic [2:0] state;
  logic       go_led, result_valid, fault, timeout;
  logic [9:0] score, best_time;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hugo_round_sequencer #(.TICK_DIV(TD), .MIN_WAIT(MW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .btn_start(bs), .btn_react(br),
    .state(state), .go_led(go_led), .score(score), .result_valid(result_valid),
    .fault(fault), .timeout(timeout), .best_time(best_time)
  );

  // Reference model: phase 0..4, enabled cycles elapsed in the phase, wait length in clocks.
  int          m_ph, m_e, m_wlen, m_score, m_best;
  bit          m_to, m_ps, m_pr;
  logic [15:0] m_lfsr;

  task automatic model_step();
    bit es, er;
    int nph;
    if (!rst_n) begin
      m_ph = 0; m_e = 0; m_wlen = 0; m_score = 0; m_best = 1023;
      m_to = 0; m_ps = 1; m_pr = 1; m_lfsr = 16'hACE1;
      return;
    end
    es = bs && !m_ps;
    er = br && !m_pr;
    m_ps = bs;
    m_pr = br;
    if (!ena) return;
    nph = m_ph;
    case (m_ph)
      0: if (es) begin nph = 1; m_wlen = (MW + int'(m_lfsr & 16'h03FF) + 1) * TD; end
      1: begin
        if (er) nph = 4;
        else if (m_e + 1 == m_wlen) nph = 2;
      end
      2: begin
        if (er) begin
          nph = 3; m_score = m_e / TD; m_to = 0;
          if (BEST_EN && m_score < m_best) m_best = m_score;
        end else if (m_e + 1 == TO * TD) begin
          nph = 3; m_score = TO; m_to = 1;
        end
      end
      default: if (es) begin nph = 1; m_wlen = (MW + int'(m_lfsr & 16'h03FF) + 1) * TD; m_to = 0; end
    endcase
    m_e = (nph != m_ph) ? 0 : m_e + 1;
    m_ph = nph;
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic cyc();
    logic [26:0] dv, mv;
    @(posedge clk);
    model_step();
    #1;
    dv = {state, go_led, score, result_valid, fault, timeout, best_time};
    mv = {3'(m_ph), m_ph == 2, 10'(m_score), m_ph == 3, m_ph == 4, m_to, 10'(m_best)};
    n_cmp++;
    if (dv !== mv) begin
      n_bad++;
      $display("FAIL model @%0t: dut {st,go,sc,rv,flt,to,best}=%h, model=%h", $time, dv, mv);
    end
  endtask

  task automatic start_round();
    bs = 1'b1;
    cyc();
    bs = 1'b0;
  endtask

  task automatic wait_go();
    bit ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      cyc();
      if (go_led === 1'b1) begin ok = 1'b1; break; end
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL wait_go: go_led=%0d after 6000 clk, expected 1", go_led);
    end
  endtask

  typedef struct {
    logic       rst_n, ena, bs, br;
    int         n;
    logic [2:0] st;
    logic       go, rv, flt;
    logic [9:0] sc;
  } vec_t;

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 3,  3'd0, 1'b0, 1'b0, 1'b0, 10'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3,  3'd0, 1'b0, 1'b0, 1'b0, 10'd0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2,  3'd0, 1'b0, 1'b0, 1'b0, 10'd0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1,  3'd1, 1'b0, 1'b0, 1'b0, 10'd0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 10, 3'd1, 1'b0, 1'b0, 1'b0, 10'd0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1,  3'd4, 1'b0, 1'b0, 1'b1, 10'd0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2,  3'd4, 1'b0, 1'b0, 1'b1, 10'd0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1,  3'd1, 1'b0, 1'b0, 1'b0, 10'd0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3,  3'd1, 1'b0, 1'b0, 1'b0, 10'd0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1,  3'd0, 1'b0, 1'b0, 1'b0, 10'd0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 2,  3'd0, 1'b0, 1'b0, 1'b0, 10'd0};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 2,  3'd0, 1'b0, 1'b0, 1'b0, 10'd0};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 3,  3'd0, 1'b0, 1'b0, 1'b0, 10'd0};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1,  3'd0, 1'b0, 1'b0, 1'b0, 10'd0};

    rst_n = 1'b0; ena = 1'b1; bs = 1'b1; br = 1'b1;

    for (int i = 0; i < 14; i++) begin
      rst_n = tbl[i].rst_n; ena = tbl[i].ena; bs = tbl[i].bs; br = tbl[i].br;
      repeat (tbl[i].n) cyc();
      chk($sformatf("vec%0d state", i), 32'(state), 32'(tbl[i].st));
      chk($sformatf("vec%0d go_led", i), 32'(go_led), 32'(tbl[i].go));
      chk($sformatf("vec%0d result_valid", i), 32'(result_valid), 32'(tbl[i].rv));
      chk($sformatf("vec%0d fault", i), 32'(fault), 32'(tbl[i].flt));
      chk($sformatf("vec%0d score", i), 32'(score), 32'(tbl[i].sc));
    end
    chk("reset best_time", 32'(best_time), 32'h3FF);

    // Normal round: react after five ticks
    start_round();
    wait_go();
    repeat (20) cyc();
    br = 1'b1; cyc(); br = 1'b0;
    chk("normal state", 32'(state), 32'd3);
    chk("normal score", 32'(score), 32'd5);
    chk("normal result_valid", 32'(result_valid), 32'd1);
    chk("normal timeout", 32'(timeout), 32'd0);
    chk("normal best", 32'(best_time), BEST_EN ? 32'd5 : 32'h3FF);

    // No press: timeout on the eighth tick
    start_round();
    wait_go();
    repeat (31) cyc();
    chk("pre-timeout state", 32'(state), 32'd2);
    cyc();
    chk("timeout state", 32'(state), 32'd3);
    chk("timeout score", 32'(score), 32'd8);
    chk("timeout flag", 32'(timeout), 32'd1);
    chk("timeout go_led", 32'(go_led), 32'd0);

    start_round();
    wait_go();
    repeat (12) cyc();
    br = 1'b1; cyc(); br = 1'b0;
    chk("round3 score", 32'(score), 32'd3);
    chk("round3 timeout", 32'(timeout), 32'd0);
    chk("round3 best", 32'(best_time), BEST_EN ? 32'd3 : 32'h3FF);

    start_round();
    wait_go();
    repeat (24) cyc();
    br = 1'b1; cyc(); br = 1'b0;
    chk("round6 score", 32'(score), 32'd6);
    chk("round6 best", 32'(best_time), BEST_EN ? 32'd3 : 32'h3FF);

    // React on the same edge as the timeout tick
    start_round();
    wait_go();
    repeat (31) cyc();
    br = 1'b1; cyc(); br = 1'b0;
    chk("race state", 32'(state), 32'd3);
    chk("race score", 32'(score), 32'd7);
    chk("race timeout", 32'(timeout), 32'd0);

    // Freeze mid-GO
    start_round();
    wait_go();
    repeat (10) cyc();
    ena = 1'b0;
    repeat (50) cyc();
    chk("freeze state", 32'(state), 32'd2);
    chk("freeze go_led", 32'(go_led), 32'd1);
    ena = 1'b1; br = 1'b1; cyc(); br = 1'b0;
    chk("freeze score", 32'(score), 32'd2);
    chk("freeze end state", 32'(state), 32'd3);

    // Reset mid-GO
    start_round();
    wait_go();
    repeat (5) cyc();
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    chk("midreset state", 32'(state), 32'd0);
    chk("midreset go_led", 32'(go_led), 32'd0);
    chk("midreset score", 32'(score), 32'd0);
    chk("midreset best", 32'(best_time), 32'h3FF);

    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 49) == 0) bs = ~bs;
      if ($urandom_range(0, 299) == 0) br = ~br;
      ena   = ($urandom_range(0, 19) != 0);
      rst_n = ($urandom_range(0, 4999) != 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
